// File: rtl/seq_multiply.sv
// Iterative shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional early completion when the remaining multiplier bits are zero: define MULT_EARLY_DONE_EN.
module seq_multiply #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     inp1,
  input  logic [WIDTH-1:0]     inp2,
  output logic [2*WIDTH-1:0]   prod,
  output logic                 rdy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, next_state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      count;
  logic               last;
  logic               load;
  logic               step;
  logic               finish;

  // BUSY spends one extra edge after the final iteration to publish the result.
`ifdef MULT_EARLY_DONE_EN
  assign last = (count == CW'(WIDTH)) || ((count != '0) && (mplier == '0));
`else
  assign last = (count == CW'(WIDTH));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start)  next_state = BUSY;
      BUSY:    if (last)   next_state = DONE;
      DONE:    if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    unique case (state)
      IDLE:    load = start;
      BUSY: begin
        step   = !last;
        finish = last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      prod   <= '0;
      rdy    <= 1'b0;
    end else begin
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, inp1};
        mplier <= inp2;
        acc    <= '0;
        count  <= '0;
      end else if (step) begin
        // The multiplicand shifts left in step with the counter, so acc += inp1 << count.
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CW'(1);
      end
      if (finish) prod <= acc;
      rdy <= (next_state == DONE);
    end
  end

endmodule

// File: tb/tb_seq_multiply.sv
// Directed testbench for seq_multiply: hand-computed products, latency and reset behaviour.
module tb_seq_multiply;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [WIDTH-1:0]   inp1;
  logic [WIDTH-1:0]   inp2;
  logic [2*WIDTH-1:0] prod;
  logic               rdy;

  int checks   = 0;
  int failures = 0;

  seq_multiply #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .inp1  (inp1),
    .inp2  (inp2),
    .prod  (prod),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int exp_latency(input logic [WIDTH-1:0] b);
`ifdef MULT_EARLY_DONE_EN
    int top;
    top = -1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) top = i;
    return (top < 0) ? 2 : top + 2;
`else
    return WIDTH + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the capture edge until rdy rises, bounded.
  task automatic wait_rdy(output int cycles);
    cycles = 0;
    while (!rdy && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_mult(input string tag, input int a, input int b, input int expected);
    int cycles;
    inp1  = WIDTH'(a);
    inp2  = WIDTH'(b);
    start = 1'b1;
    tick();
    wait_rdy(cycles);
    check({tag, "_latency"}, cycles, exp_latency(WIDTH'(b)));
    check({tag, "_prod"}, int'(prod), expected);
    start = 1'b0;
    tick();
    check({tag, "_rdy_drop"}, int'(rdy), 0);
  endtask

  initial begin
    int cycles;
    rst   = 1'b1;
    start = 1'b1;
    inp1  = 8'd10;
    inp2  = 8'd11;
    repeat (4) tick();
    check("reset_prod", int'(prod), 0);
    check("reset_rdy", int'(rdy), 0);

    // start already high as rst releases: the next edge is the capture edge
    rst = 1'b0;
    tick();
    wait_rdy(cycles);
    check("first_latency", cycles, exp_latency(8'd11));
    check("first_prod", int'(prod), 110);
    tick();
    tick();
    check("held_start_rdy", int'(rdy), 1);
    check("held_start_prod", int'(prod), 110);
    start = 1'b0;
    tick();
    check("drop_rdy", int'(rdy), 0);
    check("drop_prod_keep", int'(prod), 110);
    tick();
    check("idle_prod_keep", int'(prod), 110);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_clears_prod", int'(prod), 0);
    run_mult("m14x13", 14, 13, 182);
    run_mult("m24x34", 24, 34, 816);
    run_mult("m76x98", 76, 98, 7448);
    run_mult("m101x102", 101, 102, 10302);
    run_mult("m255x255", 255, 255, 65025);
    run_mult("m0x200", 0, 200, 0);
    run_mult("m200x0", 200, 0, 0);
    run_mult("m100x1", 100, 1, 100);
    run_mult("m100x128", 100, 128, 12800);

    // operands changed after capture must not disturb the result
    inp1  = 8'd10;
    inp2  = 8'd11;
    start = 1'b1;
    tick();
    inp1 = 8'd99;
    inp2 = 8'd77;
    wait_rdy(cycles);
    check("hold_ops_latency", cycles, exp_latency(8'd11));
    check("hold_ops_prod", int'(prod), 110);
    start = 1'b0;
    tick();

    // abort mid-operation
    inp1  = 8'd24;
    inp2  = 8'd34;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_rdy_busy", int'(rdy), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_prod", int'(prod), 0);
    check("abort_rdy", int'(rdy), 0);
    repeat (12) tick();
    check("abort_no_result", int'(rdy), 0);
    run_mult("m3x5", 3, 5, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
